// File: rtl/accum_warp_stencil_collapse.sv
// rtl/accum_warp_stencil_collapse.sv - collapses stencil tap beats back into one base-address beat
module accum_warp_stencil_collapse #(
  parameter int N_CFG  = 4,
  parameter int ABW    = 16,
  parameter int WBW    = 8,
  parameter int VDIM   = 2,
  parameter int STSIZE = 4,
  localparam int NCFG_BW = $clog2(N_CFG + 1),
  localparam int ST_BW   = $clog2(STSIZE + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               src_rdy,
  output logic                               src_ack,
  input  logic [NCFG_BW-1:0]                 i_id,
  input  logic [ABW-1:0]                     i_linear,
  input  logic [VDIM-1:0][WBW-1:0]           i_bofs,
  input  logic                               i_retire,
  input  logic                               i_islast,
  input  logic                               i_stencil,
  input  logic [N_CFG-1:0][ST_BW-1:0]        i_stencil_begs,
  input  logic [N_CFG-1:0][ST_BW-1:0]        i_stencil_ends,
  input  logic [STSIZE-1:0][ABW-1:0]         i_stencil_lut,
  output logic                               dst_rdy,
  input  logic                               dst_ack,
  output logic [NCFG_BW-1:0]                 o_id,
  output logic [VDIM-1:0][WBW-1:0]           o_bofs,
  output logic [ABW-1:0]                     o_linear,
  output logic                               o_retire,
  output logic                               o_islast,
  output logic                               o_mismatch
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ST_BW-1:0]           sid_q, sid_d;
  logic [NCFG_BW-1:0]         id_q, id_d;
  logic [VDIM-1:0][WBW-1:0]   bofs_q, bofs_d;
  logic [ABW-1:0]             base_q, base_d;
  logic                       retire_q, retire_d;
  logic                       islast_q, islast_d;
  logic                       mismatch_q, mismatch_d;

  logic [ST_BW-1:0]           beg_in;
  logic [ST_BW-1:0]           end_in;
  logic [ST_BW-1:0]           end_lat;
  logic [ABW-1:0]             lut_beg;
  logic [ABW-1:0]             lut_sid;
  logic [ST_BW:0]             beg_p1;
  logic [ST_BW-1:0]           sid_nxt;

  // Config table lookups; out-of-range ids and LUT indices read as zero
  always_comb begin
    beg_in  = '0;
    end_in  = '0;
    end_lat = '0;
    lut_beg = '0;
    lut_sid = '0;
    for (int k = 0; k < N_CFG; k++) begin
      if (i_id == NCFG_BW'(k)) begin
        beg_in = i_stencil_begs[k];
        end_in = i_stencil_ends[k];
      end
      if (id_q == NCFG_BW'(k)) begin
        end_lat = i_stencil_ends[k];
      end
    end
    for (int k = 0; k < STSIZE; k++) begin
      if (beg_in == ST_BW'(k)) begin
        lut_beg = i_stencil_lut[k];
      end
      if (sid_q == ST_BW'(k)) begin
        lut_sid = i_stencil_lut[k];
      end
    end
    beg_p1  = {1'b0, beg_in} + (ST_BW + 1)'(1);
    sid_nxt = sid_q + ST_BW'(1);
  end

  // Next-state and handshake logic; the EMIT state blocks input to hold outputs stable
  always_comb begin
    state_d    = state_q;
    sid_d      = sid_q;
    id_d       = id_q;
    bofs_d     = bofs_q;
    base_d     = base_q;
    retire_d   = retire_q;
    islast_d   = islast_q;
    mismatch_d = mismatch_q;
    src_ack    = src_rdy && (state_q != EMIT);
    dst_rdy    = (state_q == EMIT);

    case (state_q)
      IDLE: begin
        if (src_ack) begin
          id_d       = i_id;
          bofs_d     = i_bofs;
          base_d     = i_stencil ? (i_linear - lut_beg) : i_linear;
          retire_d   = i_retire;
          islast_d   = i_islast;
          mismatch_d = 1'b0;
          // Widened compare so begs+1 cannot wrap past a short ends value
          if (!i_stencil || ({1'b0, end_in} <= beg_p1)) begin
            state_d = EMIT;
          end else begin
            sid_d   = beg_p1[ST_BW-1:0];
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (src_ack) begin
          mismatch_d = mismatch_q
                     | (i_linear != (base_q + lut_sid))
                     | (i_id != id_q);
          retire_d   = retire_q | i_retire;
          islast_d   = islast_q | i_islast;
          if (sid_nxt == end_lat) begin
            state_d = EMIT;
          end else begin
            sid_d = sid_nxt;
          end
        end
      end
      EMIT: begin
        if (dst_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any partially collected group
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      sid_q      <= '0;
      id_q       <= '0;
      bofs_q     <= '0;
      base_q     <= '0;
      retire_q   <= 1'b0;
      islast_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sid_q      <= sid_d;
      id_q       <= id_d;
      bofs_q     <= bofs_d;
      base_q     <= base_d;
      retire_q   <= retire_d;
      islast_q   <= islast_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign o_id       = id_q;
  assign o_bofs     = bofs_q;
  assign o_linear   = base_q;
  assign o_retire   = retire_q;
  assign o_islast   = islast_q;
  assign o_mismatch = mismatch_q;

endmodule

// File: tb/tb_accum_warp_stencil_collapse.sv
// tb/tb_accum_warp_stencil_collapse.sv - bench for accum_warp_stencil_collapse
module tb_accum_warp_stencil_collapse;
  localparam int N_CFG   = 4;
  localparam int ABW     = 16;
  localparam int WBW     = 8;
  localparam int VDIM    = 2;
  localparam int STSIZE  = 4;
  localparam int NCFG_BW = 3;
  localparam int ST_BW   = 3;

  logic                         clk = 1'b0;
  logic                         i_rst;
  logic                         src_rdy;
  logic                         src_ack;
  logic [NCFG_BW-1:0]           i_id;
  logic [ABW-1:0]               i_linear;
  logic [VDIM-1:0][WBW-1:0]     i_bofs;
  logic                         i_retire;
  logic                         i_islast;
  logic                         i_stencil;
  logic [N_CFG-1:0][ST_BW-1:0]  i_stencil_begs;
  logic [N_CFG-1:0][ST_BW-1:0]  i_stencil_ends;
  logic [STSIZE-1:0][ABW-1:0]   i_stencil_lut;
  logic                         dst_rdy;
  logic                         dst_ack;
  logic [NCFG_BW-1:0]           o_id;
  logic [VDIM-1:0][WBW-1:0]     o_bofs;
  logic [ABW-1:0]               o_linear;
  logic                         o_retire;
  logic                         o_islast;
  logic                         o_mismatch;

  accum_warp_stencil_collapse #(
    .N_CFG(N_CFG), .ABW(ABW), .WBW(WBW), .VDIM(VDIM), .STSIZE(STSIZE)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .src_rdy(src_rdy), .src_ack(src_ack),
    .i_id(i_id), .i_linear(i_linear), .i_bofs(i_bofs),
    .i_retire(i_retire), .i_islast(i_islast), .i_stencil(i_stencil),
    .i_stencil_begs(i_stencil_begs), .i_stencil_ends(i_stencil_ends),
    .i_stencil_lut(i_stencil_lut),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack),
    .o_id(o_id), .o_bofs(o_bofs), .o_linear(o_linear),
    .o_retire(o_retire), .o_islast(o_islast), .o_mismatch(o_mismatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference configuration and one group of beats
  int m_beg[N_CFG];
  int m_end[N_CFG];
  int m_lut[STSIZE];
  int g_lin[8];
  int g_id[8];
  int g_ret[8];
  int g_isl[8];
  int g_bofs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int c = 0; c < N_CFG; c++) begin
      i_stencil_begs[c] = ST_BW'(m_beg[c]);
      i_stencil_ends[c] = ST_BW'(m_end[c]);
    end
    for (int s = 0; s < STSIZE; s++) i_stencil_lut[s] = ABW'(m_lut[s]);
  endtask

  function automatic int num_taps(input int stencil, input int id);
    if (stencil == 0 || m_end[id] <= m_beg[id] + 1) return 1;
    return m_end[id] - m_beg[id];
  endfunction

  // Drives one group starting at the current negedge, checks the collapsed beat,
  // holds it for 'hold' cycles, then consumes it; returns at the negedge after dst_ack.
  task automatic run_group(input string tag, input int stencil, input int hold);
    int n, b, base, e_mm, e_ret, e_isl;
    b     = m_beg[g_id[0]];
    n     = num_taps(stencil, g_id[0]);
    base  = (stencil != 0) ? ((g_lin[0] - m_lut[b]) & 32'hFFFF) : g_lin[0];
    e_mm  = 0;
    e_ret = 0;
    e_isl = 0;
    for (int k = 0; k < n; k++) begin
      e_ret |= g_ret[k];
      e_isl |= g_isl[k];
      if (k > 0 && (g_lin[k] != ((base + m_lut[b + k]) & 32'hFFFF) || g_id[k] != g_id[0]))
        e_mm = 1;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      src_rdy   = 1'b1;
      i_id      = NCFG_BW'(g_id[k]);
      i_linear  = ABW'(g_lin[k]);
      i_retire  = g_ret[k][0];
      i_islast  = g_isl[k][0];
      i_stencil = (k == 0) ? stencil[0] : 1'($urandom);
      i_bofs    = (k == 0) ? 16'(g_bofs) : 16'($urandom);
      #1;
      chk({tag, ".src_ack"}, src_ack, 1);
      chk({tag, ".dst_rdy_lo"}, dst_rdy, 0);
    end
    @(negedge clk);
    src_rdy  = 1'b1;
    i_linear = ABW'($urandom);
    dst_ack  = (hold == 0);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      if (h == hold) dst_ack = 1'b1;
      #1;
      chk({tag, ".dst_rdy"}, dst_rdy, 1);
      chk({tag, ".src_ack_emit"}, src_ack, 0);
      chk({tag, ".o_linear"}, o_linear, base);
      chk({tag, ".o_id"}, o_id, g_id[0]);
      chk({tag, ".o_bofs"}, o_bofs, g_bofs);
      chk({tag, ".o_retire"}, o_retire, e_ret);
      chk({tag, ".o_islast"}, o_islast, e_isl);
      chk({tag, ".o_mismatch"}, o_mismatch, e_mm);
    end
    @(negedge clk);
    dst_ack = 1'b0;
    src_rdy = 1'b0;
    #1;
    chk({tag, ".dst_rdy_after_ack"}, dst_rdy, 0);
  endtask

  task automatic clear_group();
    for (int k = 0; k < 8; k++) begin
      g_lin[k] = 0; g_id[k] = 0; g_ret[k] = 0; g_isl[k] = 0;
    end
    g_bofs = 0;
  endtask

  initial begin
    int id, st, n, base;
    i_rst = 1'b0; src_rdy = 1'b0; dst_ack = 1'b0;
    i_id = '0; i_linear = '0; i_bofs = '0; i_retire = 1'b0; i_islast = 1'b0; i_stencil = 1'b0;
    for (int c = 0; c < N_CFG; c++) begin m_beg[c] = 0; m_end[c] = 0; end
    for (int s = 0; s < STSIZE; s++) m_lut[s] = 0;
    apply_cfg();
    repeat (3) @(negedge clk);
    #1;
    chk("reset.dst_rdy", dst_rdy, 0);
    chk("reset.o_linear", o_linear, 0);
    chk("reset.o_mismatch", o_mismatch, 0);
    @(negedge clk);
    i_rst = 1'b1;

    // Non-stencil pass-through
    clear_group();
    g_lin[0] = 'h100; g_ret[0] = 1; g_bofs = 'h1234;
    run_group("nostencil", 0, 0);

    // Stencil config 1: begs=0, ends=3, lut={4,8,12}
    m_beg[1] = 0; m_end[1] = 3; m_lut[0] = 4; m_lut[1] = 8; m_lut[2] = 12; m_lut[3] = 0;
    apply_cfg();
    clear_group();
    g_lin[0] = 'h104; g_lin[1] = 'h108; g_lin[2] = 'h10C;
    g_id[0] = 1; g_id[1] = 1; g_id[2] = 1; g_isl[2] = 1; g_bofs = 'h55AA;
    run_group("stencil3", 1, 0);
    g_lin[1] = 'h10A;
    run_group("mismatch", 1, 0);
    g_lin[1] = 'h108;
    run_group("backpressure", 1, 5);
    run_group("after_bp", 1, 0);

    // Address wrap: lut[0]=0x10, single-tap stencil on config 2
    m_beg[2] = 0; m_end[2] = 1; m_lut[0] = 'h10;
    apply_cfg();
    clear_group();
    g_lin[0] = 8; g_id[0] = 2; g_ret[0] = 1;
    run_group("wrap", 1, 0);

    // Reset after 2 of 3 taps drops the partial group
    m_lut[0] = 4;
    apply_cfg();
    for (int k = 0; k < 2; k++) begin
      src_rdy = 1'b1; i_id = 3'd1; i_linear = ABW'('h104 + 4 * k);
      i_stencil = 1'b1; i_retire = 1'b1; i_islast = 1'b1; i_bofs = 16'h7777;
      @(negedge clk);
    end
    src_rdy = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid.dst_rdy", dst_rdy, 0);
    chk("rst_mid.o_linear", o_linear, 0);
    chk("rst_mid.o_retire", o_retire, 0);
    i_rst = 1'b1;
    clear_group();
    g_lin[0] = 'h204; g_lin[1] = 'h208; g_lin[2] = 'h20C;
    g_id[0] = 1; g_id[1] = 1; g_id[2] = 1; g_ret[2] = 1; g_bofs = 'h0F0F;
    run_group("rst_fresh", 1, 0);

    // Randomized groups against the reference model
    for (int r = 0; r < 60; r++) begin
      if (r % 10 == 0) begin
        for (int c = 0; c < N_CFG; c++) begin
          m_beg[c] = $urandom_range(0, STSIZE - 1);
          m_end[c] = $urandom_range(0, STSIZE);
        end
        for (int s = 0; s < STSIZE; s++) m_lut[s] = $urandom_range(0, 16'hFFFF);
        apply_cfg();
      end
      clear_group();
      id = $urandom_range(0, N_CFG - 1);
      st = ($urandom_range(0, 3) != 0) ? 1 : 0;
      n  = num_taps(st, id);
      base = $urandom_range(0, 16'hFFFF);
      g_bofs = $urandom_range(0, 16'hFFFF);
      for (int k = 0; k < n; k++) begin
        g_lin[k] = (base + ((st != 0) ? m_lut[m_beg[id] + k] : 0)) & 32'hFFFF;
        g_id[k]  = id;
        g_ret[k] = (k == n - 1) ? $urandom_range(0, 1) : (($urandom_range(0, 7) == 0) ? 1 : 0);
        g_isl[k] = (k == n - 1) ? $urandom_range(0, 1) : 0;
      end
      if (n > 1 && $urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(1, n - 1);
        if ($urandom_range(0, 1) == 0) g_lin[k] = (g_lin[k] + 1) & 32'hFFFF;
        else g_id[k] = (id + 1) % N_CFG;
      end
      run_group("random", st, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
